// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bus between decode/regfile-read, the issue stage and the ALU.
// Latency: none, this is wiring only.
// Backpressure: in_ready/in_valid on the upstream side, out_valid/alu_ready on the ALU side.
interface alu_issue_stage_if #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4,
    parameter int REG_AW = 5
);
    // upstream op
    logic              in_valid;
    logic              in_ready;
    logic [FUNC_W-1:0] in_func_code;
    logic [REG_AW-1:0] in_src_a;
    logic [REG_AW-1:0] in_src_b;
    logic              in_b_is_imm;
    logic [DATA_W-1:0] in_alu_A;
    logic [DATA_W-1:0] in_alu_B;
    logic [REG_AW-1:0] in_dest;
    // write-back snoop
    logic              wb_en;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    // ALU side
    logic              out_valid;
    logic              alu_ready;
    logic [FUNC_W-1:0] func_code;
    logic [DATA_W-1:0] alu_A;
    logic [DATA_W-1:0] alu_B;
    logic [REG_AW-1:0] out_dest;

    // environment side: feeds ops and write-backs, consumes issued ops
    modport master (
        output in_valid, in_func_code, in_src_a, in_src_b, in_b_is_imm,
               in_alu_A, in_alu_B, in_dest, wb_en, wb_addr, wb_data, alu_ready,
        input  in_ready, out_valid, func_code, alu_A, alu_B, out_dest
    );

    // issue stage side
    modport slave (
        input  in_valid, in_func_code, in_src_a, in_src_b, in_b_is_imm,
               in_alu_A, in_alu_B, in_dest, wb_en, wb_addr, wb_data, alu_ready,
        output in_ready, out_valid, func_code, alu_A, alu_B, out_dest
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: 2-entry skid buffer (main + skid) with write-back operand forwarding (ISSUE_FWD_EN).
// Latency: 1 cycle from accept to out_valid; forwarded value visible the cycle after the write-back.
// Backpressure: registered in_ready = !skid_valid; outputs held stable while out_valid & !alu_ready.
module alu_issue_stage #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 4,
    parameter int REG_AW = 5
) (
    input logic               clk,
    input logic               rst_n,
    input logic               flush,
    alu_issue_stage_if.slave  bus
);

    typedef struct packed {
        logic [FUNC_W-1:0] func;
        logic [REG_AW-1:0] src_a;
        logic [REG_AW-1:0] src_b;
        logic              b_imm;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] dest;
    } op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    op_t    main_op;
    op_t    skid_op;
    op_t    in_op;
    op_t    main_f;
    op_t    skid_f;
    op_t    in_f;
    logic   out_valid_q;
    logic   in_ready_q;
    logic   accept;
    logic   issue;

    // Pack the incoming op fields into one struct
    always_comb begin
        in_op       = '0;
        in_op.func  = bus.in_func_code;
        in_op.src_a = bus.in_src_a;
        in_op.src_b = bus.in_src_b;
        in_op.b_imm = bus.in_b_is_imm;
        in_op.a     = bus.in_alu_A;
        in_op.b     = bus.in_alu_B;
        in_op.dest  = bus.in_dest;
    end

`ifdef ISSUE_FWD_EN
    // Replace operands whose source register is being written back this cycle.
    // r0 is hardwired zero and immediates are never register values.
    function automatic op_t fwd(input op_t o, input logic en,
                                input logic [REG_AW-1:0] addr,
                                input logic [DATA_W-1:0] data);
        op_t r;
        r = o;
        if (en && addr != '0) begin
            if (addr == o.src_a)
                r.a = data;
            if (!o.b_imm && addr == o.src_b)
                r.b = data;
        end
        return r;
    endfunction

    // Forwarded view of every op that can be written into main or skid this edge
    always_comb begin
        main_f = fwd(main_op, bus.wb_en, bus.wb_addr, bus.wb_data);
        skid_f = fwd(skid_op, bus.wb_en, bus.wb_addr, bus.wb_data);
        in_f   = fwd(in_op,   bus.wb_en, bus.wb_addr, bus.wb_data);
    end
`else
    // Forwarding disabled: operands are held exactly as captured
    always_comb begin
        main_f = main_op;
        skid_f = skid_op;
        in_f   = in_op;
    end

    logic unused_wb;
    assign unused_wb = ^{bus.wb_en, bus.wb_addr, bus.wb_data};
`endif

    assign accept = bus.in_valid & in_ready_q;
    assign issue  = out_valid_q & bus.alu_ready;

    // Occupancy FSM; main/skid data and the handshake outputs are all registered here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= EMPTY;
            main_op     <= '0;
            skid_op     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            skid_op     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_op     <= in_f;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !issue) begin
                        main_op    <= main_f;
                        skid_op    <= in_f;
                        state      <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (accept && issue) begin
                        main_op <= in_f;
                    end else if (issue) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end else begin
                        main_op <= main_f;
                    end
                end
                FULL: begin
                    if (issue) begin
                        main_op    <= skid_f;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end else begin
                        main_op <= main_f;
                        skid_op <= skid_f;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.func_code = main_op.func;
    assign bus.alu_A     = main_op.a;
    assign bus.alu_B     = main_op.b;
    assign bus.out_dest  = main_op.dest;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios plus a randomized run against a queue model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Backpressure: exercised through random alu_ready, in_valid and flush.
module tb_alu_issue_stage;

    localparam int DATA_W = 32;
    localparam int FUNC_W = 4;
    localparam int REG_AW = 5;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_checks;
    int   n_fail;

    alu_issue_stage_if #(.DATA_W(DATA_W), .FUNC_W(FUNC_W), .REG_AW(REG_AW)) bus ();

    alu_issue_stage #(.DATA_W(DATA_W), .FUNC_W(FUNC_W), .REG_AW(REG_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ordered list of ops currently held by the stage (head = op at the ALU)
    typedef struct {
        logic [FUNC_W-1:0] f;
        logic [REG_AW-1:0] sa;
        logic [REG_AW-1:0] sb;
        logic              imm;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] d;
    } mop_t;

    mop_t q[$];

`ifdef ISSUE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    function automatic mop_t mfwd(input mop_t o);
        mop_t r;
        r = o;
        if (FWD && bus.wb_en && bus.wb_addr != 0) begin
            if (bus.wb_addr == o.sa) r.a = bus.wb_data;
            if (!o.imm && bus.wb_addr == o.sb) r.b = bus.wb_data;
        end
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        mop_t n;
        bit   iss;
        bit   acc;
        if (!rst_n || flush) begin
            q.delete();
            return;
        end
        iss = (q.size() > 0) && bus.alu_ready;
        acc = bus.in_valid && (q.size() < 2);
        if (iss) void'(q.pop_front());
        foreach (q[i]) q[i] = mfwd(q[i]);
        if (acc) begin
            n.f = bus.in_func_code; n.sa = bus.in_src_a; n.sb = bus.in_src_b;
            n.imm = bus.in_b_is_imm; n.a = bus.in_alu_A; n.b = bus.in_alu_B; n.d = bus.in_dest;
            q.push_back(mfwd(n));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 0; bus.in_func_code = 0; bus.in_src_a = 0; bus.in_src_b = 0;
        bus.in_b_is_imm = 0; bus.in_alu_A = 0; bus.in_alu_B = 0; bus.in_dest = 0;
        bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.alu_ready = 0;
    endtask

    task automatic put_op(input logic [3:0] f, input logic [4:0] sa, input logic [4:0] sb,
                          input logic imm, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d);
        bus.in_valid = 1; bus.in_func_code = f; bus.in_src_a = sa; bus.in_src_b = sb;
        bus.in_b_is_imm = imm; bus.in_alu_A = a; bus.in_alu_B = b; bus.in_dest = d;
    endtask

    task automatic test_reset();
        idle_inputs();
        flush = 0;
        rst_n = 0;
        step();
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
        n_checks++; if (bus.alu_A !== 32'd0 || bus.alu_B !== 32'd0) begin n_fail++; $display("FAIL reset_operands got A=%h B=%h exp 0", bus.alu_A, bus.alu_B); end
        n_checks++; if (bus.func_code !== 4'd0 || bus.out_dest !== 5'd0) begin n_fail++; $display("FAIL reset_func_dest got %h/%h exp 0", bus.func_code, bus.out_dest); end
        rst_n = 1;
        step();
    endtask

    task automatic test_single_op();
        bus.alu_ready = 1;
        put_op(4'b0000, 5'd1, 5'd2, 1'b0, 32'd5, 32'd7, 5'd9);
        step();
        bus.in_valid = 0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
        n_checks++; if (bus.alu_A !== 32'd5 || bus.alu_B !== 32'd7) begin n_fail++; $display("FAIL single_operands got A=%0d B=%0d exp 5/7", bus.alu_A, bus.alu_B); end
        n_checks++; if (bus.out_dest !== 5'd9 || bus.func_code !== 4'd0) begin n_fail++; $display("FAIL single_dest got %0d/%0d exp 9/0", bus.out_dest, bus.func_code); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.alu_ready = 0;
        put_op(4'h3, 5'd5, 5'd6, 1'b0, 32'h1111, 32'h2222, 5'd10);
        step();
        put_op(4'h4, 5'd7, 5'd8, 1'b0, 32'h3333, 32'h4444, 5'd11);
        step();
        bus.in_valid = 0;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); end
        step();
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_A !== 32'h1111 || bus.func_code !== 4'h3) begin n_fail++; $display("FAIL bp_hold_x got v=%b A=%h f=%h exp 1/1111/3", bus.out_valid, bus.alu_A, bus.func_code); end
        bus.alu_ready = 1;
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.alu_A !== 32'h3333 || bus.alu_B !== 32'h4444 || bus.out_dest !== 5'd11) begin n_fail++; $display("FAIL bp_issue_y got v=%b A=%h B=%h d=%0d exp 1/3333/4444/11", bus.out_valid, bus.alu_A, bus.alu_B, bus.out_dest); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got %b exp 1", bus.in_ready); end
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_forward();
        logic [31:0] exp_a;
        bus.alu_ready = 0;
        put_op(4'h1, 5'd3, 5'd3, 1'b1, 32'd1, 32'h55, 5'd12);
        step();
        bus.in_valid = 0;
        n_checks++; if (bus.alu_A !== 32'd1) begin n_fail++; $display("FAIL fwd_before got %h exp 1", bus.alu_A); end
        bus.wb_en = 1; bus.wb_addr = 5'd3; bus.wb_data = 32'hDEAD;
        step();
        bus.wb_en = 0;
        exp_a = FWD ? 32'hDEAD : 32'd1;
        n_checks++; if (bus.alu_A !== exp_a) begin n_fail++; $display("FAIL fwd_a got %h exp %h", bus.alu_A, exp_a); end
        n_checks++; if (bus.alu_B !== 32'h55) begin n_fail++; $display("FAIL fwd_imm_b got %h exp 55", bus.alu_B); end
        bus.wb_en = 1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1234;
        step();
        bus.wb_en = 0;
        n_checks++; if (bus.alu_A !== exp_a) begin n_fail++; $display("FAIL fwd_r0 got %h exp %h", bus.alu_A, exp_a); end
        bus.alu_ready = 1;
        step();
    endtask

    task automatic test_capture_wb();
        logic [31:0] exp_a;
        bus.alu_ready = 0;
        put_op(4'h2, 5'd4, 5'd6, 1'b0, 32'd9, 32'd2, 5'd13);
        bus.wb_en = 1; bus.wb_addr = 5'd4; bus.wb_data = 32'd42;
        step();
        bus.in_valid = 0; bus.wb_en = 0;
        exp_a = FWD ? 32'd42 : 32'd9;
        n_checks++; if (bus.alu_A !== exp_a || bus.alu_B !== 32'd2) begin n_fail++; $display("FAIL capture_wb got A=%0d B=%0d exp %0d/2", bus.alu_A, bus.alu_B, exp_a); end
        bus.alu_ready = 1;
        step();
    endtask

    task automatic test_flush_full();
        bus.alu_ready = 0;
        put_op(4'h5, 5'd1, 5'd1, 1'b0, 32'hA, 32'hB, 5'd1);
        step();
        put_op(4'h6, 5'd2, 5'd2, 1'b0, 32'hC, 32'hD, 5'd2);
        step();
        put_op(4'h7, 5'd3, 5'd3, 1'b0, 32'hE, 32'hF, 5'd3);
        flush = 1;
        step();
        flush = 0;
        bus.in_valid = 0;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got v=%b r=%b exp 0/1", bus.out_valid, bus.in_ready); end
        bus.alu_ready = 1;
        step();
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_random();
        idle_inputs();
        flush = 1;
        step();
        flush = 0;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.in_valid     = ($urandom_range(0, 99) < 60);
            bus.in_func_code = 4'($urandom());
            bus.in_src_a     = 5'($urandom_range(0, 7));
            bus.in_src_b     = 5'($urandom_range(0, 7));
            bus.in_b_is_imm  = ($urandom_range(0, 3) == 0);
            bus.in_alu_A     = $urandom();
            bus.in_alu_B     = $urandom();
            bus.in_dest      = 5'($urandom());
            bus.wb_en        = ($urandom_range(0, 1) == 1);
            bus.wb_addr      = 5'($urandom_range(0, 7));
            bus.wb_data      = $urandom();
            bus.alu_ready    = ($urandom_range(0, 99) < 50);
            flush            = ($urandom_range(0, 99) < 4);
            n_checks++; if (bus.out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, bus.out_valid, q.size() > 0); end
            n_checks++; if (bus.in_ready !== (q.size() < 2)) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, bus.in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                n_checks++;
                if (bus.func_code !== q[0].f || bus.alu_A !== q[0].a || bus.alu_B !== q[0].b || bus.out_dest !== q[0].d) begin
                    n_fail++;
                    $display("FAIL rnd_op cyc %0d got f=%h A=%h B=%h d=%0d exp f=%h A=%h B=%h d=%0d",
                             cyc, bus.func_code, bus.alu_A, bus.alu_B, bus.out_dest, q[0].f, q[0].a, q[0].b, q[0].d);
                end
            end
            model_edge();
            step();
        end
        flush = 0;
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 0;
        flush    = 0;
        idle_inputs();
        test_reset();
        test_single_op();
        test_backpressure();
        test_forward();
        test_capture_wb();
        test_flush_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
